// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter for NREQ local requesters that turns
// each accepted command into one APB transfer (IDLE -> SETUP -> ACCESS) and
// is the sole driver of the APB master signals. All outputs are registered.
// Optional build macro APB_ARB_PREADY_EN adds a pready input so the slave can
// stretch ACCESS with wait states; without it ACCESS is always one cycle.
module apb_req_arbiter #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic                   pclk,
   input  logic                   presetn,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_write,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [NREQ-1:0]        done,
   output logic [DATA_W-1:0]      rdata,
   output logic                   psel,
   output logic                   penable,
   output logic                   pwrite,
   output logic [ADDR_W-1:0]      paddr,
   output logic [DATA_W-1:0]      pwdata,
   input  logic [DATA_W-1:0]      prdata
`ifdef APB_ARB_PREADY_EN
   ,
   input  logic                   pready
`endif
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  last;        // most recent winner; also owner of the in-flight transfer
   logic [IDX_W-1:0]  win_idx;
   logic              win_found;
   logic [IDX_W-1:0]  scan_idx;
   logic              access_end;
   logic              accept;
   logic [ADDR_W-1:0] addr_arr  [NREQ];
   logic [DATA_W-1:0] wdata_arr [NREQ];

   // Unpack the per-requester address/data buses for indexed selection.
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
   end

`ifdef APB_ARB_PREADY_EN
   assign access_end = pready;
`else
   assign access_end = 1'b1;
`endif

   // Round-robin search starting one past the last winner, wrapping at NREQ.
   always_comb begin
      win_idx   = last;
      win_found = 1'b0;
      scan_idx  = last;
      for (int k = 0; k < NREQ; k++) begin
         if (scan_idx == IDX_W'(NREQ - 1)) begin
            scan_idx = '0;
         end else begin
            scan_idx = scan_idx + IDX_W'(1);
         end
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   // A command is taken from IDLE, or straight from the completing ACCESS edge.
   assign accept = win_found &&
                   ((state == ST_IDLE) || ((state == ST_ACCESS) && access_end));

   // APB sequencer: state and every output are registered here.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state   <= ST_IDLE;
         psel    <= 1'b0;
         penable <= 1'b0;
         pwrite  <= 1'b0;
         paddr   <= '0;
         pwdata  <= '0;
         gnt     <= '0;
         done    <= '0;
         rdata   <= '0;
         last    <= IDX_W'(NREQ - 1);
      end else begin
         gnt  <= '0;
         done <= '0;
         case (state)
            ST_IDLE: begin
            end
            ST_SETUP: begin
               state   <= ST_ACCESS;
               penable <= 1'b1;
            end
            ST_ACCESS: begin
               // Without pready the slave has no wait states; otherwise hold
               // everything until it signals completion.
               if (access_end) begin
                  if (!pwrite) begin
                     rdata <= prdata;
                  end
                  done[last] <= 1'b1;
                  state      <= ST_IDLE;
                  psel       <= 1'b0;
                  penable    <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               psel    <= 1'b0;
               penable <= 1'b0;
            end
         endcase
         // A new acceptance overrides the return to IDLE (back-to-back keeps psel high).
         if (accept) begin
            state         <= ST_SETUP;
            psel          <= 1'b1;
            penable       <= 1'b0;
            pwrite        <= req_write[win_idx];
            paddr         <= addr_arr[win_idx];
            pwdata        <= wdata_arr[win_idx];
            gnt[win_idx]  <= 1'b1;
            last          <= win_idx;
         end
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: randomized and directed stimulus for apb_req_arbiter,
// checked against a transaction-scheduling reference model. Build with
// APB_ARB_PREADY_EN defined to exercise slave wait states as well.
module tb_apb_req_arbiter;

   localparam int NREQ   = 2;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int ASZ    = 2048;
   localparam int QD     = 16;

   typedef struct packed {
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } cmd_t;

   logic                   pclk;
   logic                   presetn;
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        req_write;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        done;
   logic [DATA_W-1:0]      rdata;
   logic                   psel;
   logic                   penable;
   logic                   pwrite;
   logic [ADDR_W-1:0]      paddr;
   logic [DATA_W-1:0]      pwdata;
   logic [DATA_W-1:0]      prdata;
   logic                   pready;

   logic              req_a [NREQ];
   logic              wr_a  [NREQ];
   logic [ADDR_W-1:0] ad_a  [NREQ];
   logic [DATA_W-1:0] wd_a  [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign req[g]                       = req_a[g];
      assign req_write[g]                 = wr_a[g];
      assign req_addr[g*ADDR_W +: ADDR_W] = ad_a[g];
      assign req_wdata[g*DATA_W +: DATA_W] = wd_a[g];
   end

   apb_req_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .rdata     (rdata),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata)
`ifdef APB_ARB_PREADY_EN
      ,
      .pready    (pready)
`endif
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // APB slave: 256-byte memory, zero-latency read data
   logic [DATA_W-1:0] slv_mem [256];
   logic              mem_clr;
   assign prdata = slv_mem[paddr];

   always @(posedge pclk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) slv_mem[i] <= 8'(i * 7 + 3);
      end else if (psel && penable && pwrite && pready) begin
         slv_mem[paddr] <= pwdata;
      end
   end

   // Reference model state: expected outputs per sample index
   logic [NREQ-1:0]   exp_gnt   [ASZ];
   logic [NREQ-1:0]   exp_done  [ASZ];
   logic              exp_psel  [ASZ];
   logic              exp_pen   [ASZ];
   logic              exp_wr    [ASZ];
   logic [ADDR_W-1:0] exp_addr  [ASZ];
   logic [DATA_W-1:0] exp_wd    [ASZ];
   logic [DATA_W-1:0] exp_rdata [ASZ];
   logic              rdy_at    [ASZ];
   int                acc_req   [ASZ];
   logic [DATA_W-1:0] ref_mem   [256];
   logic [DATA_W-1:0] hold_rd;
   int                cur_edge, free_edge, busy_until, m_last;
   int                n_checks, n_pass;
`ifdef APB_ARB_PREADY_EN
   int                force_waits;
`endif

   cmd_t cq [NREQ][QD];
   int   qh [NREQ];
   int   qt [NREQ];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s @sample %0d: got %0h expected %0h", tag, cur_edge, obs, expv);
   endtask

   task automatic clear_from(input int s);
      for (int i = s; i < ASZ; i++) begin
         exp_gnt[i]   = '0;
         exp_done[i]  = '0;
         exp_psel[i]  = 1'b0;
         exp_pen[i]   = 1'b0;
         exp_wr[i]    = 1'b0;
         exp_addr[i]  = '0;
         exp_wd[i]    = '0;
         exp_rdata[i] = '0;
         rdy_at[i]    = 1'b1;
         acc_req[i]   = -1;
      end
   endtask

   task automatic push_cmd(input int n, input logic w, input logic [7:0] a, input logic [7:0] d);
      cq[n][qt[n] % QD] = {w, a, d};
      qt[n]++;
   endtask

   function automatic bit pending_any();
      bit p = 1'b0;
      for (int n = 0; n < NREQ; n++) if (qh[n] != qt[n]) p = 1'b1;
      return p;
   endfunction

   task automatic drive_inputs();
      cmd_t c;
      for (int n = 0; n < NREQ; n++) begin
         if (qh[n] != qt[n]) begin
            c        = cq[n][qh[n] % QD];
            req_a[n] = 1'b1;
            wr_a[n]  = c.w;
            ad_a[n]  = c.a;
            wd_a[n]  = c.d;
         end else begin
            req_a[n] = 1'b0;
            wr_a[n]  = 1'($urandom);
            ad_a[n]  = 8'($urandom);
            wd_a[n]  = 8'($urandom);
         end
      end
      pready = rdy_at[cur_edge + 1];
   endtask

   // Schedule the whole life of a command accepted at the coming edge
   task automatic model_edge();
      int   e, w, waits, n;
      cmd_t c;
      e     = cur_edge + 1;
      w     = -1;
      waits = 0;
      if (presetn && e >= free_edge && e + 8 < ASZ) begin
         for (int k = 1; k <= NREQ; k++) begin
            n = (m_last + k) % NREQ;
            if (w < 0 && req_a[n]) w = n;
         end
         if (w >= 0) begin
            c = cq[w][qh[w] % QD];
`ifdef APB_ARB_PREADY_EN
            waits = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 2));
`endif
            exp_gnt[e] = NREQ'(1) << w;
            for (int s = e; s <= e + 1 + waits; s++) begin
               exp_psel[s] = 1'b1;
               exp_addr[s] = c.a;
               exp_wd[s]   = c.d;
               exp_wr[s]   = c.w;
            end
            for (int s = e + 1; s <= e + 1 + waits; s++) exp_pen[s] = 1'b1;
            for (int s = e + 2; s <= e + 1 + waits; s++) rdy_at[s] = 1'b0;
            if (c.w) ref_mem[c.a] = c.d;
            else     hold_rd      = ref_mem[c.a];
            exp_done[e + 2 + waits]  = NREQ'(1) << w;
            exp_rdata[e + 2 + waits] = hold_rd;
            acc_req[e] = w;
            m_last     = w;
            free_edge  = e + 2 + waits;
            busy_until = free_edge;
         end
      end
   endtask

   task automatic check_sample(input int s);
      chk("gnt",     32'(gnt),     32'(exp_gnt[s]));
      chk("done",    32'(done),    32'(exp_done[s]));
      chk("psel",    32'(psel),    32'(exp_psel[s]));
      chk("penable", 32'(penable), 32'(exp_pen[s]));
      if (exp_psel[s]) begin
         chk("paddr",  32'(paddr),  32'(exp_addr[s]));
         chk("pwdata", 32'(pwdata), 32'(exp_wd[s]));
         chk("pwrite", 32'(pwrite), 32'(exp_wr[s]));
      end
      if (exp_done[s] != '0) chk("rdata", 32'(rdata), 32'(exp_rdata[s]));
   endtask

   task automatic cycle();
      drive_inputs();
      model_edge();
      @(negedge pclk);
      cur_edge++;
      check_sample(cur_edge);
      if (acc_req[cur_edge] >= 0) qh[acc_req[cur_edge]]++;
   endtask

   task automatic apply_reset(input int hold);
      presetn = 1'b0;
      #1;
      chk("rst_psel",    32'(psel),    32'd0);
      chk("rst_penable", 32'(penable), 32'd0);
      chk("rst_pwrite",  32'(pwrite),  32'd0);
      chk("rst_paddr",   32'(paddr),   32'd0);
      chk("rst_pwdata",  32'(pwdata),  32'd0);
      chk("rst_gnt",     32'(gnt),     32'd0);
      chk("rst_done",    32'(done),    32'd0);
      chk("rst_rdata",   32'(rdata),   32'd0);
      clear_from(cur_edge + 1);
      m_last     = NREQ - 1;
      free_edge  = 0;
      busy_until = 0;
      hold_rd    = '0;
      for (int i = 0; i < hold; i++) cycle();
      presetn = 1'b1;
   endtask

   task automatic run_idle(input int max);
      int n = 0;
      while ((pending_any() || cur_edge <= busy_until) && n < max) begin
         cycle();
         n++;
      end
      if (n >= max) chk("drain_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int n;
      n_checks = 0;
      n_pass   = 0;
      cur_edge = 0;
      free_edge = 0;
      busy_until = 0;
      m_last   = NREQ - 1;
      hold_rd  = '0;
      presetn  = 1'b1;
      mem_clr  = 1'b1;
      pready   = 1'b1;
`ifdef APB_ARB_PREADY_EN
      force_waits = 0;
`endif
      for (int i = 0; i < NREQ; i++) begin
         qh[i] = 0; qt[i] = 0;
         req_a[i] = 1'b0; wr_a[i] = 1'b0; ad_a[i] = '0; wd_a[i] = '0;
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
      clear_from(0);
      #1;
      apply_reset(2);
      mem_clr = 1'b0;

      // single write, then read it back, then a write must not disturb rdata
      push_cmd(0, 1'b1, 8'h10, 8'hA5);
      run_idle(20);
      chk("mem10", 32'(slv_mem[8'h10]), 32'h0000_00A5);
      push_cmd(1, 1'b0, 8'h10, 8'h00);
      run_idle(20);
      chk("rdata_rd", 32'(rdata), 32'h0000_00A5);
      push_cmd(0, 1'b1, 8'h30, 8'h5A);
      run_idle(20);
      chk("rdata_hold", 32'(rdata), 32'h0000_00A5);

      // contention straight out of reset: requester 0 first, back-to-back
      apply_reset(2);
      push_cmd(0, 1'b1, 8'h20, 8'h11);
      push_cmd(1, 1'b1, 8'h21, 8'h22);
      run_idle(20);
      chk("mem20", 32'(slv_mem[8'h20]), 32'h0000_0011);
      chk("mem21", 32'(slv_mem[8'h21]), 32'h0000_0022);

      // fairness: both keep a command pending on every grant
      for (int i = 0; i < 4; i++) begin
         push_cmd(0, 1'b1, 8'(8'h40 + i), 8'(8'hC0 + i));
         push_cmd(1, 1'b0, 8'(8'h40 + i), 8'h00);
      end
      run_idle(40);

      // reset while a read is in ACCESS
      push_cmd(1, 1'b0, 8'h10, 8'h00);
      n = 0;
      while (!exp_pen[cur_edge] && n < 20) begin
         cycle();
         n++;
      end
      if (n >= 20) chk("access_timeout", 32'd1, 32'd0);
      apply_reset(2);
      push_cmd(1, 1'b0, 8'h21, 8'h00);
      push_cmd(0, 1'b1, 8'h50, 8'h77);
      run_idle(20);

`ifdef APB_ARB_PREADY_EN
      // three wait states on a single write
      force_waits = 3;
      push_cmd(0, 1'b1, 8'h60, 8'h3C);
      run_idle(20);
      force_waits = -1;
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         for (int r = 0; r < NREQ; r++) begin
            if (qh[r] == qt[r] && $urandom_range(0, 2) == 0)
               push_cmd(r, 1'($urandom), 8'($urandom_range(0, 31)), 8'($urandom));
         end
         cycle();
      end
      run_idle(50);

      for (int i = 0; i < 256; i++) chk("mem", 32'(slv_mem[i]), 32'(ref_mem[i]));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
